// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: definitions shared by the multicycle MIPS core and its
// load/store unit.
//   lsu_op_t    - data-memory operation code. The core decodes its opcode
//                 into this type.
//   lsu_state_t - load/store unit FSM state. The ST_* constants are the
//                 state encodings.
//   lsuIsStore  - true for the operations that drive a bus write.
package mips_cpu_pkg;

    typedef enum logic [3:0] {
        LSU_LB  = 4'd0,
        LSU_LBU = 4'd1,
        LSU_LH  = 4'd2,
        LSU_LHU = 4'd3,
        LSU_LW  = 4'd4,
        LSU_LWL = 4'd5,
        LSU_LWR = 4'd6,
        LSU_SB  = 4'd7,
        LSU_SH  = 4'd8,
        LSU_SW  = 4'd9
    } lsu_op_t;

    typedef logic [2:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE  = 3'd0;
    localparam lsu_state_t ST_RD    = 3'd1;
    localparam lsu_state_t ST_CAP   = 3'd2;
    localparam lsu_state_t ST_WR    = 3'd3;
    localparam lsu_state_t ST_FAULT = 3'd4;
    localparam lsu_state_t ST_RESP  = 3'd5;

    function automatic logic lsuIsStore(input logic [3:0] op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// mips_cpu_lsu_align: combinational byte-lane logic for the load/store unit.
// Little-endian byte order: byte offset k selects lane k, which is bits
// [8k+7:8k].
//   op         in  4   lsu_op_t operation code
//   offset     in  2   byte offset, addr[1:0]
//   readdata   in  32  word returned by the bus
//   rtOld      in  32  current rt value; the merge source for LWL/LWR
//   storeData  in  32  rt value to be stored
//   byteenable out 4   lanes the access touches
//   writedata  out 32  store data replicated into the addressed lanes
//   loadData   out 32  extended or merged load result
//   misaligned out 1   access cannot be performed; undefined op codes also
//                      raise it
module mips_cpu_lsu_align
    import mips_cpu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] readdata,
    input  logic [31:0] rtOld,
    input  logic [31:0] storeData,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic [31:0] loadData,
    output logic        misaligned
);

    logic [4:0]  shLo;      // 8*k
    logic [4:0]  shHi;      // 8*(3-k); for a 2-bit k, 3-k equals ~k
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] mergeMask; // set bits come from memory, clear bits from rtOld

    assign shLo     = {offset, 3'b000};
    assign shHi     = {~offset, 3'b000};
    assign laneByte = readdata[shLo +: 8];
    assign laneHalf = offset[1] ? readdata[31:16] : readdata[15:0];

    always_comb begin
        byteenable = 4'b0000;
        writedata  = 32'h0;
        loadData   = 32'h0;
        misaligned = 1'b0;
        mergeMask  = 32'h0;
        case (op)
            LSU_LB: begin
                byteenable = 4'b0001 << offset;
                loadData   = {{24{laneByte[7]}}, laneByte};
            end
            LSU_LBU: begin
                byteenable = 4'b0001 << offset;
                loadData   = {24'h0, laneByte};
            end
            LSU_LH: begin
                byteenable = offset[1] ? 4'b1100 : 4'b0011;
                misaligned = offset[0];
                loadData   = {{16{laneHalf[15]}}, laneHalf};
            end
            LSU_LHU: begin
                byteenable = offset[1] ? 4'b1100 : 4'b0011;
                misaligned = offset[0];
                loadData   = {16'h0, laneHalf};
            end
            LSU_LW: begin
                byteenable = 4'b1111;
                misaligned = (offset != 2'b00);
                loadData   = readdata;
            end
            LSU_LWL: begin
                // Memory lanes 0..k fill the top bytes of rt.
                byteenable = 4'b1111 >> ~offset;
                mergeMask  = 32'hFFFF_FFFF << shHi;
                loadData   = (readdata << shHi) | (rtOld & ~mergeMask);
            end
            LSU_LWR: begin
                // Memory lanes k..3 fill the bottom bytes of rt.
                byteenable = 4'b1111 << offset;
                mergeMask  = 32'hFFFF_FFFF >> shLo;
                loadData   = (readdata >> shLo) | (rtOld & ~mergeMask);
            end
            LSU_SB: begin
                byteenable = 4'b0001 << offset;
                writedata  = {4{storeData[7:0]}};
            end
            LSU_SH: begin
                byteenable = offset[1] ? 4'b1100 : 4'b0011;
                misaligned = offset[0];
                writedata  = {2{storeData[15:0]}};
            end
            LSU_SW: begin
                byteenable = 4'b1111;
                misaligned = (offset != 2'b00);
                writedata  = storeData;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_cpu_lsu.sv
// mips_cpu_lsu: load/store unit between the multicycle MIPS core and an
// Avalon-MM data port. It runs one access at a time.
// Core side:
//   req, op, addr, store_data, rt_old  request; sampled only in IDLE
//   busy, done, load_data, misaligned  status and result
// Avalon side:
//   address, read, write, writedata, byteenable, waitrequest, readdata
// Debug:
//   lsuState  current FSM state, encoded as the ST_* constants
// Handshake: a transfer on the bus completes on the first edge where read
// or write is high and waitrequest is low. address, byteenable and writedata
// stay stable until that edge. readdata is taken one cycle after the accepting
// edge. On the core side, req is a single-cycle strobe that is accepted only in
// IDLE. done pulses for one cycle, and load_data and misaligned are valid in
// that cycle.
module mips_cpu_lsu
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] rt_old,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata,
    output logic [2:0]  lsuState
);

    lsu_state_t  state;
    lsu_state_t  stateNext;

    logic [3:0]  opQ;
    logic [31:0] addrQ;
    logic [31:0] storeDataQ;
    logic [31:0] rtOldQ;

    logic        accept;
    logic        nextOnBus;
    logic [3:0]  srcOp;
    logic [31:0] srcAddr;
    logic [31:0] srcStoreData;
    logic [31:0] srcRtOld;

    logic [3:0]  alBe;
    logic [31:0] alWd;
    logic [31:0] alLoad;
    logic        alMis;

    assign accept = (state == ST_IDLE) && req;

    // In IDLE the request inputs are the source. The bus registers are loaded
    // on the same edge that latches the request, so they need this path.
    // In every other state the latched copies are the source, so the core may
    // change its inputs after acceptance.
    assign srcOp        = (state == ST_IDLE) ? op         : opQ;
    assign srcAddr      = (state == ST_IDLE) ? addr       : addrQ;
    assign srcStoreData = (state == ST_IDLE) ? store_data : storeDataQ;
    assign srcRtOld     = (state == ST_IDLE) ? rt_old     : rtOldQ;

    mips_cpu_lsu_align uAlign (
        .op         (srcOp),
        .offset     (srcAddr[1:0]),
        .readdata   (readdata),
        .rtOld      (srcRtOld),
        .storeData  (srcStoreData),
        .byteenable (alBe),
        .writedata  (alWd),
        .loadData   (alLoad),
        .misaligned (alMis)
    );

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (alMis) begin
                        stateNext = ST_FAULT;
                    end else if (lsuIsStore(op)) begin
                        stateNext = ST_WR;
                    end else begin
                        stateNext = ST_RD;
                    end
                end
            end
            ST_RD:    if (!waitrequest) stateNext = ST_CAP;
            ST_CAP:   stateNext = ST_RESP;
            ST_WR:    if (!waitrequest) stateNext = ST_RESP;
            ST_FAULT: stateNext = ST_RESP;
            ST_RESP:  stateNext = ST_IDLE;
            default:  stateNext = ST_IDLE;
        endcase
    end

    assign nextOnBus = (stateNext == ST_RD) || (stateNext == ST_WR);

    // The outputs are registered and decoded from the next state. The bus
    // strobes therefore rise on the accepting edge and fall on the edge where
    // waitrequest is low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            opQ        <= 4'h0;
            addrQ      <= 32'h0;
            storeDataQ <= 32'h0;
            rtOldQ     <= 32'h0;
            busy       <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            load_data  <= 32'h0;
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= RESET_ADDR;
            byteenable <= 4'b0000;
            writedata  <= 32'h0;
        end else begin
            state <= stateNext;
            if (accept) begin
                opQ        <= op;
                addrQ      <= addr;
                storeDataQ <= store_data;
                rtOldQ     <= rt_old;
            end
            busy       <= (stateNext == ST_RD) || (stateNext == ST_CAP) ||
                          (stateNext == ST_WR) || (stateNext == ST_FAULT);
            done       <= (stateNext == ST_RESP);
            misaligned <= (state == ST_FAULT);
            if (state == ST_CAP) begin
                load_data <= alLoad;
            end
            read       <= (stateNext == ST_RD);
            write      <= (stateNext == ST_WR);
            address    <= nextOnBus ? {srcAddr[31:2], 2'b00} : RESET_ADDR;
            byteenable <= nextOnBus ? alBe : 4'b0000;
            writedata  <= nextOnBus ? alWd : 32'h0;
        end
    end

    assign lsuState = state;

endmodule

// File: tb/tb_mips_cpu_lsu.sv
module tb_mips_cpu_lsu;
  import mips_cpu_pkg::*;

  localparam logic [31:0] RST_ADDR = 32'hBFC0_0000;

  logic        clk;
  logic        reset;
  logic        req;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] rt_old;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest = 1'b0;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata = 32'h0;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // {is_load, misaligned, load_data}
  logic [33:0] exp_q[$];
  // {is_write, address, byteenable, writedata, cycles strobe is high}
  logic [76:0] bus_q[$];

  int          cur_stalls = 0;
  logic [31:0] mem_word   = 32'h0;

  mips_cpu_lsu #(.RESET_ADDR(RST_ADDR)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .op          (op),
    .addr        (addr),
    .store_data  (store_data),
    .rt_old      (rt_old),
    .busy        (busy),
    .done        (done),
    .load_data   (load_data),
    .misaligned  (misaligned),
    .address     (address),
    .read        (read),
    .write       (write),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata),
    .lsuState    (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
  endtask

  // ---------------- reference model (byte-level) ----------------
  function automatic bit ref_is_store(input logic [3:0] o);
    return (o == LSU_SB) || (o == LSU_SH) || (o == LSU_SW);
  endfunction

  function automatic bit ref_mis(input logic [3:0] o, input logic [1:0] k);
    int kk = int'(k);
    case (o)
      LSU_LH, LSU_LHU, LSU_SH: return (kk % 2) != 0;
      LSU_LW, LSU_SW:          return kk != 0;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [3:0] o, input logic [1:0] k);
    int kk = int'(k);
    int lo = kk;
    int hi = kk;
    logic [3:0] be = 4'b0000;
    case (o)
      LSU_LH, LSU_LHU, LSU_SH: hi = kk + 1;
      LSU_LW, LSU_SW: begin lo = 0; hi = 3; end
      LSU_LWL: lo = 0;
      LSU_LWR: hi = 3;
      default: ;
    endcase
    for (int i = 0; i < 4; i++) if (i >= lo && i <= hi) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] ref_wd(input logic [3:0] o, input logic [31:0] sd);
    case (o)
      LSU_SB:  return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
      LSU_SH:  return {sd[15:0], sd[15:0]};
      LSU_SW:  return sd;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] o, input logic [1:0] k,
                                           input logic [31:0] m, input logic [31:0] rt);
    logic [7:0] mb[4];
    logic [7:0] rb[4];
    int kk = int'(k);
    for (int i = 0; i < 4; i++) begin
      mb[i] = m[8*i +: 8];
      rb[i] = rt[8*i +: 8];
    end
    case (o)
      LSU_LB:  return {{24{mb[kk][7]}}, mb[kk]};
      LSU_LBU: return {24'h0, mb[kk]};
      LSU_LH:  return {{16{mb[kk+1][7]}}, mb[kk+1], mb[kk]};
      LSU_LHU: return {16'h0, mb[kk+1], mb[kk]};
      LSU_LW:  return m;
      LSU_LWL: begin
        for (int j = 0; j <= kk; j++) rb[3-j] = mb[kk-j];
        return {rb[3], rb[2], rb[1], rb[0]};
      end
      LSU_LWR: begin
        for (int j = kk; j < 4; j++) rb[j-kk] = mb[j];
        return {rb[3], rb[2], rb[1], rb[0]};
      end
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic garble();
    req        = 1'($urandom_range(0, 1));
    op         = 4'($urandom_range(0, 9));
    addr       = $urandom;
    store_data = $urandom;
    rt_old     = $urandom;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rt, input logic [31:0] m, input int stalls,
                       input bit fixed, input logic [31:0] want);
    bit          mis;
    bit          st;
    logic [31:0] data;
    int          lat;
    int          cyc;
    mis  = ref_mis(o, a[1:0]);
    st   = ref_is_store(o);
    data = fixed ? want : ref_load(o, a[1:0], m, rt);
    exp_q.push_back({~st, mis, data});
    if (!mis)
      bus_q.push_back({st, {a[31:2], 2'b00}, ref_be(o, a[1:0]), ref_wd(o, sd), 8'(stalls + 1)});
    lat = mis ? 2 : (st ? 2 + stalls : 3 + stalls);
    cur_stalls = stalls;
    mem_word   = m;
    @(negedge clk);
    req = 1'b1; op = o; addr = a; store_data = sd; rt_old = rt;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("busy_after_accept", {31'h0, busy}, 32'h1);
      garble();
    end while (!done && cyc < 64);
    if (!done) chk("done_timeout", 32'h0, 32'h1);
    else chk("latency", cyc, lat);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_read"},       {31'h0, read},       32'h0);
    chk({tag, "_write"},      {31'h0, write},      32'h0);
    chk({tag, "_busy"},       {31'h0, busy},       32'h0);
    chk({tag, "_done"},       {31'h0, done},       32'h0);
    chk({tag, "_misaligned"}, {31'h0, misaligned}, 32'h0);
    chk({tag, "_byteenable"}, {28'h0, byteenable}, 32'h0);
    chk({tag, "_writedata"},  writedata,           32'h0);
    chk({tag, "_load_data"},  load_data,           32'h0);
    chk({tag, "_address"},    address,             RST_ADDR);
    chk({tag, "_state"},      {29'h0, dbg_state},  {29'h0, ST_IDLE});
  endtask

  // ---------------- Avalon memory responder ----------------
  bit resp_active = 1'b0;
  bit rd_pending  = 1'b0;
  int remaining   = 0;

  always @(negedge clk) begin
    readdata = $urandom;
    if (rd_pending) begin
      readdata   = mem_word;
      rd_pending = 1'b0;
    end
    if (read || write) begin
      if (!resp_active) begin
        resp_active = 1'b1;
        remaining   = cur_stalls;
      end
      if (remaining > 0) begin
        waitrequest = 1'b1;
        remaining--;
      end else begin
        waitrequest = 1'b0;
        resp_active = 1'b0;
        rd_pending  = read;
      end
    end else begin
      resp_active = 1'b0;
      waitrequest = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [33:0] e;
    if (done) begin
      chk("busy_at_done", {31'h0, busy}, 32'h0);
      if (exp_q.size() == 0) begin
        chk("done_unexpected", 32'h1, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("misaligned", {31'h0, misaligned}, {31'h0, e[32]});
        if (e[33] && !e[32]) chk("load_data", load_data, e[31:0]);
      end
    end
  end

  bit          prev_act = 1'b0;
  bit          have_cur = 1'b0;
  logic [76:0] cur_bus  = '0;
  int          bus_len  = 0;

  always @(negedge clk) begin
    bit act;
    act = read || write;
    if (act && !prev_act) begin
      if (bus_q.size() == 0) begin
        have_cur = 1'b0;
        chk("bus_unexpected", 32'h1, 32'h0);
      end else begin
        have_cur = 1'b1;
        cur_bus  = bus_q.pop_front();
        chk("bus_dir",  {30'h0, write, read}, cur_bus[76] ? 32'h2 : 32'h1);
        chk("bus_addr", address, cur_bus[75:44]);
        chk("bus_be",   {28'h0, byteenable}, {28'h0, cur_bus[43:40]});
        chk("bus_wdata", writedata, cur_bus[39:8]);
      end
      bus_len = 1;
    end else if (act && prev_act) begin
      bus_len++;
      if (have_cur) begin
        chk("bus_stable_addr", address, cur_bus[75:44]);
        chk("bus_stable_be",   {28'h0, byteenable}, {28'h0, cur_bus[43:40]});
        chk("bus_stable_wdata", writedata, cur_bus[39:8]);
      end
    end else if (!act && prev_act) begin
      if (have_cur) chk("bus_len", bus_len, {24'h0, cur_bus[7:0]});
      have_cur = 1'b0;
    end else begin
      chk("idle_address", address, RST_ADDR);
      chk("idle_be", {28'h0, byteenable}, 32'h0);
      chk("idle_wdata", writedata, 32'h0);
    end
    prev_act = act;
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; req = 1'b0; op = 4'h0; addr = 32'h0; store_data = 32'h0; rt_old = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    @(negedge clk);

    issue(LSU_LW,  32'h0000_1000, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF);
    issue(LSU_LB,  32'h0000_1003, 32'h0, 32'h0, 32'h80FF_FFFF, 0, 1, 32'hFFFF_FF80);
    issue(LSU_LBU, 32'h0000_1003, 32'h0, 32'h0, 32'h80FF_FFFF, 0, 1, 32'h0000_0080);
    issue(LSU_SH,  32'h0000_2002, 32'h0000_ABCD, 32'h0, 32'h0, 3, 0, 32'h0);
    issue(LSU_LWL, 32'h0000_3001, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, 32'hCCDD_3344);
    issue(LSU_LWR, 32'h0000_3001, 32'h0, 32'h1122_3344, 32'hAABB_CCDD, 0, 1, 32'h11AA_BBCC);
    issue(LSU_LH,  32'h0000_4001, 32'h0, 32'h0, 32'h1234_5678, 0, 0, 32'h0);
    issue(LSU_LHU, 32'h0000_4002, 32'h0, 32'h0, 32'h8765_4321, 2, 1, 32'h0000_8765);
    issue(LSU_SB,  32'h0000_4001, 32'h0000_005A, 32'h0, 32'h0, 1, 0, 32'h0);
    issue(LSU_SW,  32'h0000_4004, 32'h1357_9BDF, 32'h0, 32'h0, 2, 0, 32'h0);
    issue(LSU_SW,  32'h0000_4006, 32'h1357_9BDF, 32'h0, 32'h0, 0, 0, 32'h0);

    // reset while a read is stalled
    bus_q.push_back({1'b0, 32'h0000_5000, 4'b1111, 32'h0, 8'd3});
    cur_stalls = 20;
    mem_word   = 32'hCAFE_F00D;
    @(negedge clk);
    req = 1'b1; op = LSU_LW; addr = 32'h0000_5000; store_data = 32'h0; rt_old = 32'h0;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("abort");
    reset = 1'b1;
    issue(LSU_LW, 32'h0000_5004, 32'h0, 32'h0, 32'h0BAD_CAFE, 1, 1, 32'h0BAD_CAFE);

    for (int i = 0; i < 250; i++) begin
      logic [3:0]  o;
      logic [31:0] a;
      o = 4'($urandom_range(0, 9));
      a = $urandom;
      issue(o, a, $urandom, $urandom, $urandom, $urandom_range(0, 3), 0, 32'h0);
    end

    req = 1'b0;
    repeat (6) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 32'h0);
    chk("bus_q_drained", bus_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
